// File: rtl/tick_scheduler.sv
// Multi-channel programmable clock-enable generator: per-channel divisor counters
// emitting tick pulses and square waves, with config updates deferred to period boundaries.
module tick_scheduler #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEFAULT_DIV = 4,
  localparam int unsigned CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CW-1:0]       cfg_chan,
  input  logic [WIDTH-1:0]    cfg_div,
  input  logic                cfg_enable,
  output logic                cfg_err,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] sq,
  output logic [CHANNELS-1:0] active,
  output logic [CHANNELS-1:0] pending
);

  logic [WIDTH-1:0]    div_q   [CHANNELS];
  logic [WIDTH-1:0]    div_d   [CHANNELS];
  logic [WIDTH-1:0]    count_q [CHANNELS];
  logic [WIDTH-1:0]    count_d [CHANNELS];
  logic [WIDTH-1:0]    pdiv_q  [CHANNELS];
  logic [WIDTH-1:0]    pdiv_d  [CHANNELS];
  logic [CHANNELS-1:0] en_q, en_d;
  logic [CHANNELS-1:0] pen_q, pen_d;
  logic [CHANNELS-1:0] pvalid_q, pvalid_d;
  logic [CHANNELS-1:0] tick_q, tick_d;
  logic [CHANNELS-1:0] sq_q, sq_d;
  logic [CHANNELS-1:0] active_q, active_d;
  logic                cfg_err_q, cfg_err_d;

  logic                chan_ok_c;
  logic [CHANNELS-1:0] idle_c, wrap_c, apply_c, wr_c;

  // Out-of-range channels are always ready so the write can be dropped and flagged.
  always_comb begin
    chan_ok_c = 5'(cfg_chan) < 5'(CHANNELS);
    cfg_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_chan == CW'(i)) cfg_ready = !pvalid_q[i];
    end
  end

  always_comb begin
    idle_c  = '0;
    wrap_c  = '0;
    apply_c = '0;
    wr_c    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      idle_c[i]  = !en_q[i] || (div_q[i] == '0);
      wrap_c[i]  = !idle_c[i] && (count_q[i] == div_q[i] - WIDTH'(1));
      apply_c[i] = pvalid_q[i] && (idle_c[i] || wrap_c[i]);
      wr_c[i]    = cfg_valid && cfg_ready && chan_ok_c && (cfg_chan == CW'(i));
    end
  end

  always_comb begin
    div_d     = div_q;
    count_d   = count_q;
    pdiv_d    = pdiv_q;
    en_d      = en_q;
    pen_d     = pen_q;
    pvalid_d  = pvalid_q;
    tick_d    = '0;
    sq_d      = '0;
    active_d  = '0;
    cfg_err_d = cfg_valid && !chan_ok_c;
    for (int i = 0; i < CHANNELS; i++) begin
      if (apply_c[i]) begin
        div_d[i]    = pdiv_q[i];
        en_d[i]     = pen_q[i];
        count_d[i]  = '0;
        pvalid_d[i] = 1'b0;
        if (pen_q[i] && (pdiv_q[i] != '0)) begin
          tick_d[i] = wrap_c[i];
          sq_d[i]   = 1'b1;
        end
      end else if (!idle_c[i]) begin
        if (wrap_c[i]) begin
          count_d[i] = '0;
          tick_d[i]  = 1'b1;
        end else begin
          count_d[i] = count_q[i] + WIDTH'(1);
        end
        // High for the first ceil(D/2) counts of each period.
        sq_d[i] = count_d[i] < ((div_q[i] >> 1) + WIDTH'(div_q[i][0]));
      end else begin
        count_d[i] = '0;
      end
      // pvalid is low whenever a write is accepted, so this never collides with apply.
      if (wr_c[i]) begin
        pdiv_d[i]   = cfg_div;
        pen_d[i]    = cfg_enable;
        pvalid_d[i] = 1'b1;
      end
      active_d[i] = en_d[i] && (div_d[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        div_q[i]   <= WIDTH'(DEFAULT_DIV);
        count_q[i] <= '0;
        pdiv_q[i]  <= '0;
      end
      en_q      <= '0;
      pen_q     <= '0;
      pvalid_q  <= '0;
      tick_q    <= '0;
      sq_q      <= '0;
      active_q  <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      count_q   <= count_d;
      pdiv_q    <= pdiv_d;
      en_q      <= en_d;
      pen_q     <= pen_d;
      pvalid_q  <= pvalid_d;
      tick_q    <= tick_d;
      sq_q      <= sq_d;
      active_q  <= active_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign tick    = tick_q;
  assign sq      = sq_q;
  assign active  = active_q;
  assign pending = pvalid_q;
  assign cfg_err = cfg_err_q;

endmodule
